// File: rtl/matrix_reader_if.sv
// Handshake bundle between the matrix reader and its stream source / buffer sink.
// slave is the reader side; master is the producer and buffer side.
interface matrix_reader_if #(
  parameter int IDX_W = 5
);
  logic              start;
  logic [31:0]       in_value;
  logic              in_stb;
  logic              in_ack;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_i;
  logic [IDX_W-1:0]  wr_j;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;

  modport slave (
    input  start, in_value, in_stb,
    output in_ack, wr_en, wr_i, wr_j, wr_data, busy, done
  );

  modport master (
    output start, in_value, in_stb,
    input  in_ack, wr_en, wr_i, wr_j, wr_data, busy, done
  );
endinterface

// File: rtl/matrix_reader.sv
// Loads one N x N matrix of 32-bit words from a stb/ack stream into the matrix buffer,
// one registered write per accepted word, with optional column-major (transposed) ordering.
module matrix_reader #(
  parameter int N         = 8,
  parameter int IDX_W     = 5,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  matrix_reader_if.slave   bus
);

  localparam int DATA_W = 32;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    i_q, i_d, j_q, j_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ack_q, ack_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    data_d  = data_q;
    ack_d   = ack_q;
    wren_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          i_d     = '0;
          j_d     = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          ack_d   = 1'b1;
        end
      end

      S_READ: begin
        if (bus.in_stb && ack_q) begin
          data_d  = bus.in_value;
          ack_d   = 1'b0;
          wren_d  = 1'b1;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // Counters hold the final element once the load completes; they never wrap.
        if (i_q == LAST && j_q == LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
          ack_d   = 1'b1;
          if (!TRANSPOSE) begin
            if (j_q == LAST) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            if (i_q == LAST) begin
              i_d = '0;
              j_d = j_q + 1'b1;
            end else begin
              i_d = i_q + 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The index counters are held through S_WRITE, so they double as the write address.
  assign bus.in_ack  = ack_q;
  assign bus.wr_en   = wren_q;
  assign bus.wr_i    = i_q;
  assign bus.wr_j    = j_q;
  assign bus.wr_data = data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
